ks_addsub64_seq: RTL and testbench

- Multi-cycle 64-bit add/subtract unit for the pipe ALU.
- It time-shares one 32-bit Kogge-Stone adder: the low half is computed in one cycle, and the high half in the next cycle using the registered low carry.
- Adds the subtract direction, with borrow semantics, alongside the existing add path.
- Uses a valid/ready handshake on both sides so the execute stage can stall it.

---
 rtl/alu_pkg.sv | 17 +
 rtl/KoggeStone32Bit.sv | 42 ++++
 rtl/ks_addsub64_seq.sv | 117 +++++++++++
 tb/tb_ks_addsub64_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcode and state encodings for the pipe ALU add/subtract unit.
package alu_pkg;

  localparam int ALU_W  = 64;
  localparam int HALF_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/KoggeStone32Bit.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module KoggeStone32Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  logic [31:0] p_bit;
  logic [31:0] g_lvl;
  logic [31:0] p_lvl;
  logic [31:0] g_nxt;
  logic [31:0] p_nxt;
  logic [31:0] carry;

  // Five log-depth prefix levels; g_lvl[i]/p_lvl[i] end up spanning bits i..0.
  always_comb begin
    p_bit = A ^ B;
    g_lvl = A & B;
    p_lvl = p_bit;
    g_nxt = '0;
    p_nxt = '0;
    for (int k = 0; k < 5; k++) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int i = (1 << k); i < 32; i++) begin
        g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i - (1 << k)]);
        p_nxt[i] = p_lvl[i] & p_lvl[i - (1 << k)];
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
    carry[0] = Cin;
    for (int i = 1; i < 32; i++) begin
      carry[i] = g_lvl[i-1] | (p_lvl[i-1] & Cin);
    end
    S    = p_bit ^ carry;
    Cout = g_lvl[31] | (p_lvl[31] & Cin);
  end

endmodule

// File: rtl/ks_addsub64_seq.sv
// Multi-cycle 64-bit add/subtract: one shared 32-bit Kogge-Stone adder computes
// the low half, then the high half with the registered low carry.
module ks_addsub64_seq
  import alu_pkg::*;
#(
  parameter bit EARLY_READY  = 1'b0,
  parameter bit ZERO_FLAG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_op,
  input  logic        in_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_s,
  output logic        out_c,
  output logic        out_ovf,
  output logic        out_zero,
  output logic        out_neg
);

  state_e              state_q, state_d;
  logic [ALU_W-1:0]    a_q, b_q;
  logic                cin_q, op_q;
  logic [HALF_W-1:0]   s_lo_q;
  logic                c_mid_q;
  logic [ALU_W-1:0]    out_s_q;
  logic                out_c_q, out_ovf_q, out_zero_q, out_neg_q;

  logic                accept;
  logic [HALF_W-1:0]   add_a, add_b, add_s;
  logic                add_cin, add_cout;

  assign in_ready = (state_q == ST_IDLE) ||
                    (EARLY_READY && (state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Operand mux: only HI selects the upper halves and the registered mid carry.
  always_comb begin
    add_a   = a_q[HALF_W-1:0];
    add_b   = b_q[HALF_W-1:0];
    add_cin = cin_q;
    if (state_q == ST_HI) begin
      add_a   = a_q[ALU_W-1:HALF_W];
      add_b   = b_q[ALU_W-1:HALF_W];
      add_cin = c_mid_q;
    end
  end

  KoggeStone32Bit u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (add_cin),
    .S    (add_s),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? ST_LO : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Subtract is a + ~b + ~borrow_in, so the carry-out is inverted back into a borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      op_q       <= 1'b0;
      s_lo_q     <= '0;
      c_mid_q    <= 1'b0;
      out_s_q    <= '0;
      out_c_q    <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
      out_neg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= (in_op == OP_SUB) ? ~in_b : in_b;
        cin_q <= (in_op == OP_SUB) ? ~in_c : in_c;
        op_q  <= in_op;
      end
      if (state_q == ST_LO) begin
        s_lo_q  <= add_s;
        c_mid_q <= add_cout;
      end
      if (state_q == ST_HI) begin
        out_s_q    <= {add_s, s_lo_q};
        out_c_q    <= add_cout ^ op_q;
        out_ovf_q  <= (a_q[ALU_W-1] == b_q[ALU_W-1]) && (add_s[HALF_W-1] != a_q[ALU_W-1]);
        out_zero_q <= ZERO_FLAG_EN ? ({add_s, s_lo_q} == '0) : 1'b0;
        out_neg_q  <= add_s[HALF_W-1];
      end
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_s     = out_s_q;
  assign out_c     = out_c_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;
  assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_ks_addsub64_seq.sv
// Self-checking bench for ks_addsub64_seq (EARLY_READY=1) against an arithmetic reference model.
module tb_ks_addsub64_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_op;
  logic        in_c;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_s;
  logic        out_c;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;

  int total;
  int bad;

  ks_addsub64_seq #(
    .EARLY_READY  (1'b1),
    .ZERO_FLAG_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packing used throughout: {carry/borrow, ovf, zero, neg, sum}.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic op, input logic c);
    logic [64:0]        u;
    logic signed [64:0] sv;
    logic [63:0]        s;
    if (op == 1'b0) begin
      u  = {1'b0, a} + {1'b0, b} + 65'(c);
      sv = $signed({a[63], a}) + $signed({b[63], b}) + $signed(65'(c));
    end else begin
      u  = {1'b0, a} - {1'b0, b} - 65'(c);
      sv = $signed({a[63], a}) - $signed({b[63], b}) - $signed(65'(c));
    end
    s = u[63:0];
    return {u[64], (sv[64] != sv[63]), (s == 64'd0), s[63], s};
  endfunction

  function automatic logic [67:0] observed();
    return {out_c, out_ovf, out_zero, out_neg, out_s};
  endfunction

  // Issue one operation from IDLE; returns the result once out_valid rises and the
  // cycle index at which it rose (1 = the cycle right after the accepting edge).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic op,
                        input logic c, output logic [67:0] res, output int lat);
    int n;
    in_a = a; in_b = b; in_op = op; in_c = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_op = 1'($urandom_range(0, 1));
    in_c = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = observed();
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, observed()} !== 69'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {out_valid, observed()});
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta [6];
    logic [63:0] tb [6];
    logic        top [6];
    logic        tc [6];
    logic [67:0] texp [6];
    logic [67:0] res;
    int          lat;
    ta[0] = 64'h0000_0000_FFFF_FFFF; tb[0] = 64'd1; top[0] = 1'b0; tc[0] = 1'b0;
    texp[0] = {4'b0000, 64'h0000_0001_0000_0000};
    ta[1] = 64'd0; tb[1] = 64'd1; top[1] = 1'b1; tc[1] = 1'b0;
    texp[1] = {4'b1001, 64'hFFFF_FFFF_FFFF_FFFF};
    ta[2] = 64'd5; tb[2] = 64'd3; top[2] = 1'b1; tc[2] = 1'b1;
    texp[2] = {4'b0000, 64'd1};
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'd1; top[3] = 1'b0; tc[3] = 1'b0;
    texp[3] = {4'b0101, 64'h8000_0000_0000_0000};
    ta[4] = 64'h8000_0000_0000_0000; tb[4] = 64'h8000_0000_0000_0000; top[4] = 1'b1; tc[4] = 1'b0;
    texp[4] = {4'b0010, 64'd0};
    ta[5] = 64'hFFFF_FFFF_FFFF_FFFF; tb[5] = 64'd1; top[5] = 1'b0; tc[5] = 1'b0;
    texp[5] = {4'b1010, 64'd0};
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], top[i], tc[i], res, lat);
      total++;
      if (lat !== 3) begin
        bad++;
        $display("FAIL directed_latency[%0d] got=%0d want=3", i, lat);
      end
      total++;
      if (res !== texp[i]) begin
        bad++;
        $display("FAIL directed_result[%0d] got=%h want=%h", i, res, texp[i]);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b;
    logic [67:0] res, exp;
    int          lat;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp = model(a, b, 1'b0, 1'b1);
    run_op(a, b, 1'b0, 1'b1, res, lat);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (observed() !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure[%0d] got res=%h valid=%b ready=%b want res=%h valid=1 ready=0",
                 i, observed(), out_valid, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    retire();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_retire got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a2, b2;
    logic [67:0] res, exp2;
    int          lat;
    run_op(64'd100, 64'd58, 1'b1, 1'b0, res, lat);
    total++;
    if (res !== model(64'd100, 64'd58, 1'b1, 1'b0)) begin
      bad++;
      $display("FAIL b2b_first got=%h want=%h", res, model(64'd100, 64'd58, 1'b1, 1'b0));
    end
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    exp2 = model(a2, b2, 1'b1, 1'b1);
    in_a = a2; in_b = b2; in_op = 1'b1; in_c = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_early_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_valid_drop got=%b want=0", out_valid);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat !== 3 || observed() !== exp2) begin
      bad++;
      $display("FAIL b2b_second got lat=%0d res=%h want lat=3 res=%h", lat, observed(), exp2);
    end
    retire();
  endtask

  task automatic test_reset_mid();
    int seen;
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321;
    in_op = 1'b0; in_c = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    total++;
    if ({out_valid, observed()} !== 69'd0) begin
      bad++;
      $display("FAIL reset_mid_clear got=%h want=0", {out_valid, observed()});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_pulse got bad_cycles=%0d want=0", seen);
    end
  endtask

  task automatic test_sweep();
    logic [67:0] res, exp;
    logic        c;
    int          lat;
    int          errs;
    errs = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int op = 0; op < 2; op++) begin
          c = 1'($urandom_range(0, 1));
          exp = model(64'(a), 64'(b), 1'(op), c);
          run_op(64'(a), 64'(b), 1'(op), c, res, lat);
          total++;
          if (res !== exp || lat !== 3) begin
            bad++;
            errs++;
            if (errs < 8)
              $display("FAIL sweep a=%0d b=%0d op=%0d c=%0d got=%h lat=%0d want=%h lat=3",
                       a, b, op, c, res, lat, exp);
          end
          retire();
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic        op, c;
    logic [67:0] res, exp;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 4 == 0) b = a;
      if (i % 7 == 0) a[63:32] = 32'hFFFF_FFFF;
      op = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      exp = model(a, b, op, c);
      run_op(a, b, op, c, res, lat);
      total++;
      if (res !== exp) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h op=%b c=%b got=%h want=%h", i, a, b, op, c, res, exp);
      end
      retire();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = 1'b0;
    in_c = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
